// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with registered read data,
// per-cycle write/read ack/err handshake and programmable almost-full/empty.
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_CNT    = cnt_t'(AE_LEVEL);

  // Reject illegal parameter combinations at elaboration.
  if (ADDR_WIDTH < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("param_fifo: illegal parameters ADDR_WIDTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           ADDR_WIDTH, AF_LEVEL, AE_LEVEL);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  addr_t                 head;
  addr_t                 tail;
  logic                  wa;
  logic                  ra;

  // Status flags decoded only from the registered count.
  always_comb begin
    full         = (data_count == DEPTH_CNT);
    empty        = (data_count == '0);
    almost_full  = (data_count >= AF_CNT);
    almost_empty = (data_count <= AE_CNT);
  end

  // Accept decisions; a full FIFO still takes a write if a read frees a slot
  // on the same edge, an empty FIFO never bypasses write data to the read.
  always_comb begin
    wa = wr_en & (~full | rd_en);
    ra = rd_en & ~empty;
  end

  // Storage array write port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (wa) begin
      mem[tail] <= din;
    end
  end

  // Pointers, count, registered read data and handshake pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (wa) begin
        tail <= tail + addr_t'(1);
      end
      if (ra) begin
        dout <= mem[head];
        head <= head + addr_t'(1);
      end
      case ({wa, ra})
        2'b10:   data_count <= data_count + cnt_t'(1);
        2'b01:   data_count <= data_count - cnt_t'(1);
        default: data_count <= data_count;
      endcase
      wr_ack <= wa;
      wr_err <= wr_en & ~wa;
      rd_ack <= ra;
      rd_err <= rd_en & ~ra;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo (default 8x32).
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] din;
  logic        rd_en;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  param_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .dout        (dout),
    .data_count  (data_count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .rd_ack      (rd_ack),
    .rd_err      (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_hs(input string tag, input logic wa, input logic we,
                        input logic ra, input logic re);
    chk({tag, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, wa});
    chk({tag, ".wr_err"}, {31'd0, wr_err}, {31'd0, we});
    chk({tag, ".rd_ack"}, {31'd0, rd_ack}, {31'd0, ra});
    chk({tag, ".rd_err"}, {31'd0, rd_err}, {31'd0, re});
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".count"}, {28'd0, data_count}, 32'd0);
    chk({tag, ".empty"}, {31'd0, empty}, 32'd1);
    chk({tag, ".aempty"}, {31'd0, almost_empty}, 32'd1);
    chk({tag, ".full"}, {31'd0, full}, 32'd0);
    chk({tag, ".afull"}, {31'd0, almost_full}, 32'd0);
    chk({tag, ".dout"}, dout, 32'd0);
    chk_hs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    // Reset for two cycles, then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_cleared("reset");
    step(1'b0, 32'h0, 1'b0);
    chk_cleared("idle");

    // Fill to full with 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      v = 32'h11 * i;
      step(1'b1, v, 1'b0);
      chk_hs("fill", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fill.count", {28'd0, data_count}, i);
      chk("fill.afull", {31'd0, almost_full}, (i >= 6) ? 32'd1 : 32'd0);
      chk("fill.full", {31'd0, full}, (i == 8) ? 32'd1 : 32'd0);
      chk("fill.aempty", {31'd0, almost_empty}, (i <= 2) ? 32'd1 : 32'd0);
    end

    // Write while full is rejected.
    step(1'b1, 32'hEE, 1'b0);
    chk_hs("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf.count", {28'd0, data_count}, 32'd8);

    // Drain in order.
    for (int i = 1; i <= 8; i++) begin
      v = 32'h11 * i;
      step(1'b0, 32'h0, 1'b1);
      chk_hs("drain", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain.dout", dout, v);
      chk("drain.count", {28'd0, data_count}, 8 - i);
      chk("drain.aempty", {31'd0, almost_empty}, (8 - i <= 2) ? 32'd1 : 32'd0);
      chk("drain.empty", {31'd0, empty}, (i == 8) ? 32'd1 : 32'd0);
    end

    // Read while empty is rejected and dout holds.
    step(1'b0, 32'h0, 1'b1);
    chk_hs("udf", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("udf.dout", dout, 32'h88);
    chk("udf.empty", {31'd0, empty}, 32'd1);

    // Empty with both requests: write only, no bypass.
    step(1'b1, 32'h5A, 1'b1);
    chk_hs("both_empty", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("both_empty.count", {28'd0, data_count}, 32'd1);
    chk("both_empty.dout", dout, 32'h88);

    // Refill to full, then both requests while full.
    for (int i = 1; i <= 7; i++) step(1'b1, i, 1'b0);
    chk("refill.count", {28'd0, data_count}, 32'd8);
    chk("refill.full", {31'd0, full}, 32'd1);
    step(1'b1, 32'h99, 1'b1);
    chk_hs("both_full", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("both_full.count", {28'd0, data_count}, 32'd8);
    chk("both_full.dout", dout, 32'h5A);

    // Remaining order: 1..7 then 0x99.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("drain2.dout", dout, (i == 8) ? 32'h99 : i);
    end
    chk("drain2.count", {28'd0, data_count}, 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk_hs("quiet", 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap-around: three rounds of 5 writes / 5 reads.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 32'hA00 + 16 * r + k, 1'b0);
      chk("wrap.count5", {28'd0, data_count}, 32'd5);
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 32'h0, 1'b1);
        chk("wrap.dout", dout, 32'hA00 + 16 * r + k);
      end
      chk("wrap.count0", {28'd0, data_count}, 32'd0);
    end

    // Asynchronous reset mid-stream with five entries held.
    for (int k = 0; k < 5; k++) step(1'b1, 32'hC0 + k, 1'b0);
    chk("pre_rst.count", {28'd0, data_count}, 32'd5);
    chk("pre_rst.dout", dout, 32'hA24);
    #3 reset = 1'b1;
    #1;
    chk_cleared("async_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    chk_cleared("rst_hold");
    step(1'b1, 32'hAB, 1'b0);
    chk_hs("post_wr", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_wr.count", {28'd0, data_count}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    chk_hs("post_rd", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rd.dout", dout, 32'hAB);
    chk("post_rd.empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
